// File: rtl/dev_bus_pkg.sv
// rtl/dev_bus_pkg.sv - shared device-bus types, idle address and device address map
package dev_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    localparam logic [31:0] IDLE_ADDR_DEFAULT = 32'hFFFF_FFFF;

    // Device namespace shared by bus masters and device controllers
    localparam logic [31:0] DEV_HEX = 32'hF000_0000;
    localparam logic [31:0] DEV_LED = 32'hF000_0004;
    localparam logic [31:0] DEV_KEY = 32'hF000_0010;
    localparam logic [31:0] DEV_SW  = 32'hF000_0014;

    function automatic logic [1:0] ack_vec(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - combinational two-way round-robin chooser
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       valid,
    output logic       winner
);

    // Requester 1 wins when alone, or when both ask and 0 had the last turn
    always_comb begin
        valid  = |req;
        winner = req[1] & (~req[0] | ~last_grant);
    end

endmodule

// File: rtl/dev_bus_arbiter.sv
// rtl/dev_bus_arbiter.sv - two-master round-robin arbiter for the device bus
module dev_bus_arbiter
    import dev_bus_pkg::*;
#(
    parameter int               DBITS         = 32,
    parameter int               ACCESS_CYCLES = 1,
    parameter logic [DBITS-1:0] IDLE_ADDR     = DBITS'(IDLE_ADDR_DEFAULT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             we0,
    input  logic [DBITS-1:0] addr0,
    input  logic [DBITS-1:0] wdata0,
    output logic             ack0,
    input  logic             req1,
    input  logic             we1,
    input  logic [DBITS-1:0] addr1,
    input  logic [DBITS-1:0] wdata1,
    output logic             ack1,
    output logic [DBITS-1:0] rdata,
    output logic             busy,
    output logic             gnt_id,
    output logic [DBITS-1:0] address,
    output logic             wrtEn,
    inout  wire  [DBITS-1:0] dbus
);

    localparam int            CW       = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(ACCESS_CYCLES - 1);

    state_t           state, state_next;
    logic [CW-1:0]    cnt, cnt_next;
    logic [DBITS-1:0] wdata_q, wdata_next;
    logic [DBITS-1:0] address_next, rdata_next;
    logic             wrtEn_next, dbus_oe, dbus_oe_next;
    logic             ack0_next, ack1_next, busy_next;
    logic             gnt_next, last_grant, last_next;
    logic             pick_valid, pick_winner;

    rr_pick2 u_pick (
        .req        ({req1, req0}),
        .last_grant (last_grant),
        .valid      (pick_valid),
        .winner     (pick_winner)
    );

    // The address/wrtEn registers double as the latched request while in ACCESS
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        wdata_next   = wdata_q;
        rdata_next   = rdata;
        gnt_next     = gnt_id;
        last_next    = last_grant;
        address_next = IDLE_ADDR;
        wrtEn_next   = 1'b0;
        dbus_oe_next = 1'b0;
        ack0_next    = 1'b0;
        ack1_next    = 1'b0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_next   = ACCESS;
                    cnt_next     = CNT_LOAD;
                    gnt_next     = pick_winner;
                    last_next    = pick_winner;
                    address_next = pick_winner ? addr1 : addr0;
                    wrtEn_next   = pick_winner ? we1 : we0;
                    dbus_oe_next = wrtEn_next;
                    wdata_next   = pick_winner ? wdata1 : wdata0;
                end
            end
            ACCESS: begin
                address_next = address;
                wrtEn_next   = wrtEn;
                dbus_oe_next = wrtEn;
                if (cnt != '0) begin
                    cnt_next = cnt - CW'(1);
                end else begin
                    state_next   = ACK;
                    address_next = IDLE_ADDR;
                    wrtEn_next   = 1'b0;
                    dbus_oe_next = 1'b0;
                    {ack1_next, ack0_next} = ack_vec(gnt_id);
                    if (!wrtEn) begin
                        rdata_next = dbus;
                    end
                end
            end
            ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            address    <= IDLE_ADDR;
            wrtEn      <= 1'b0;
            dbus_oe    <= 1'b0;
            wdata_q    <= '0;
            rdata      <= '0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            busy       <= 1'b0;
            gnt_id     <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            address    <= address_next;
            wrtEn      <= wrtEn_next;
            dbus_oe    <= dbus_oe_next;
            wdata_q    <= wdata_next;
            rdata      <= rdata_next;
            ack0       <= ack0_next;
            ack1       <= ack1_next;
            busy       <= busy_next;
            gnt_id     <= gnt_next;
            last_grant <= last_next;
        end
    end

    assign dbus = dbus_oe ? wdata_q : {DBITS{1'bz}};

endmodule

// File: tb/tb_dev_bus_arbiter.sv
// tb/tb_dev_bus_arbiter.sv - directed self-checking bench for dev_bus_arbiter
module tb_dev_bus_arbiter;
    import dev_bus_pkg::*;

    localparam logic [31:0] PATTERN = 32'h5A5A_C3C3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [31:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
    logic        ack0, ack1, busy, gnt_id, wrtEn;
    logic [31:0] rdata, address;
    wire  [31:0] dbus;

    logic        r3_req = 1'b0;
    logic [31:0] r3_addr = '0;
    logic        r3_ack0, r3_ack1, r3_busy, r3_gnt, r3_wrtEn;
    logic [31:0] r3_rdata, r3_address, dev3_val = '0;
    wire  [31:0] dbus3;

    logic        tb_force = 1'b0;
    logic [31:0] hex_reg = '0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    // HEX controller model plus an optional bench drive used to prove the bus is released
    assign dbus  = tb_force ? PATTERN : ((!wrtEn && address == DEV_HEX) ? hex_reg : 32'hzzzz_zzzz);
    assign dbus3 = (!r3_wrtEn && r3_address == DEV_HEX) ? dev3_val : 32'hzzzz_zzzz;

    always @(posedge clk) begin
        if (wrtEn && address == DEV_HEX) hex_reg <= dbus;
    end

    dev_bus_arbiter u1 (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
        .rdata(rdata), .busy(busy), .gnt_id(gnt_id),
        .address(address), .wrtEn(wrtEn), .dbus(dbus)
    );

    dev_bus_arbiter #(.ACCESS_CYCLES(3)) u3 (
        .clk(clk), .reset(reset),
        .req0(r3_req), .we0(1'b0), .addr0(r3_addr), .wdata0(32'h0), .ack0(r3_ack0),
        .req1(1'b0), .we1(1'b0), .addr1(32'h0), .wdata1(32'h0), .ack1(r3_ack1),
        .rdata(r3_rdata), .busy(r3_busy), .gnt_id(r3_gnt),
        .address(r3_address), .wrtEn(r3_wrtEn), .dbus(dbus3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        checks++;
        if (address !== 32'hFFFF_FFFF || wrtEn !== 1'b0 || busy !== 1'b0 || gnt_id !== 1'b0) begin
            failures++;
            $display("FAIL reset_bus: address=%h wrtEn=%b busy=%b gnt=%b required FFFFFFFF 0 0 0", address, wrtEn, busy, gnt_id);
        end
        checks++;
        if (ack0 !== 1'b0 || ack1 !== 1'b0 || rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_ack: ack0=%b ack1=%b rdata=%h required 0 0 0", ack0, ack1, rdata);
        end
        tb_force = 1'b1;
        #1;
        checks++;
        if (dbus !== PATTERN) begin
            failures++;
            $display("FAIL reset_dbus_z: dbus=%h required %h", dbus, PATTERN);
        end
        tb_force = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_write();
        req0 = 1'b1; we0 = 1'b1; addr0 = DEV_HEX; wdata0 = 32'h0000_1234;
        step();
        checks++;
        if (address !== DEV_HEX || wrtEn !== 1'b1 || dbus !== 32'h0000_1234 || busy !== 1'b1 || gnt_id !== 1'b0) begin
            failures++;
            $display("FAIL write_access: addr=%h wrtEn=%b dbus=%h busy=%b gnt=%b required F0000000 1 00001234 1 0", address, wrtEn, dbus, busy, gnt_id);
        end
        req0 = 1'b0;
        step();
        checks++;
        if (ack0 !== 1'b1 || ack1 !== 1'b0 || wrtEn !== 1'b0 || address !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL write_ack: ack0=%b ack1=%b wrtEn=%b addr=%h required 1 0 0 FFFFFFFF", ack0, ack1, wrtEn, address);
        end
        checks++;
        if (hex_reg !== 32'h0000_1234 || rdata !== 32'h0) begin
            failures++;
            $display("FAIL write_hex: hex=%h rdata=%h required 00001234 00000000", hex_reg, rdata);
        end
        tb_force = 1'b1;
        #1;
        checks++;
        if (dbus !== PATTERN) begin
            failures++;
            $display("FAIL write_ack_dbus_z: dbus=%h required %h", dbus, PATTERN);
        end
        tb_force = 1'b0;
        step();
        checks++;
        if (ack0 !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL write_idle: ack0=%b busy=%b required 0 0", ack0, busy);
        end
    endtask

    task automatic test_read();
        req1 = 1'b1; we1 = 1'b0; addr1 = DEV_HEX; wdata1 = 32'hDEAD_BEEF;
        step();
        checks++;
        if (gnt_id !== 1'b1 || wrtEn !== 1'b0 || address !== DEV_HEX || dbus !== 32'h0000_1234) begin
            failures++;
            $display("FAIL read_access: gnt=%b wrtEn=%b addr=%h dbus=%h required 1 0 F0000000 00001234", gnt_id, wrtEn, address, dbus);
        end
        req1 = 1'b0;
        step();
        checks++;
        if (ack1 !== 1'b1 || ack0 !== 1'b0 || rdata !== 32'h0000_1234) begin
            failures++;
            $display("FAIL read_ack: ack1=%b ack0=%b rdata=%h required 1 0 00001234", ack1, ack0, rdata);
        end
        step();
        step();
        checks++;
        if (ack1 !== 1'b0 || rdata !== 32'h0000_1234) begin
            failures++;
            $display("FAIL read_hold: ack1=%b rdata=%h required 0 00001234", ack1, rdata);
        end
    endtask

    task automatic test_simultaneous();
        logic [1:0] exp_ack;
        do_reset();
        req0 = 1'b1; we0 = 1'b1; addr0 = DEV_LED; wdata0 = 32'h11;
        req1 = 1'b1; we1 = 1'b1; addr1 = DEV_LED; wdata1 = 32'h22;
        for (int k = 1; k <= 12; k++) begin
            step();
            exp_ack = {(k == 5 || k == 11), (k == 2 || k == 8)};
            checks++;
            if ({ack1, ack0} !== exp_ack) begin
                failures++;
                $display("FAIL rr_ack cycle %0d: ack1ack0=%b required %b", k, {ack1, ack0}, exp_ack);
            end
            if (k % 3 == 1) begin
                checks++;
                if (gnt_id !== 1'((k / 3) % 2)) begin
                    failures++;
                    $display("FAIL rr_gnt cycle %0d: gnt=%b required %0d", k, gnt_id, (k / 3) % 2);
                end
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL rr_stop: busy=%b required 0", busy);
        end
    endtask

    task automatic test_long_access();
        r3_req = 1'b1; r3_addr = DEV_HEX; dev3_val = 32'h111;
        step();
        r3_req = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            checks++;
            if (r3_address !== DEV_HEX || r3_ack0 !== 1'b0 || r3_busy !== 1'b1) begin
                failures++;
                $display("FAIL long_hold cycle %0d: addr=%h ack0=%b busy=%b required F0000000 0 1", k, r3_address, r3_ack0, r3_busy);
            end
            if (k == 1) dev3_val = 32'h222;
            if (k == 2) dev3_val = 32'h333;
            if (k < 3) step();
        end
        step();
        dev3_val = 32'h444;
        checks++;
        if (r3_ack0 !== 1'b1 || r3_rdata !== 32'h333 || r3_address !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL long_ack: ack0=%b rdata=%h addr=%h required 1 00000333 FFFFFFFF", r3_ack0, r3_rdata, r3_address);
        end
    endtask

    task automatic test_req_dropped();
        int acks;
        req0 = 1'b1; we0 = 1'b1; addr0 = DEV_LED; wdata0 = 32'h55;
        step();
        req0 = 1'b0;
        acks = 0;
        for (int k = 2; k <= 8; k++) begin
            step();
            if (ack0 === 1'b1) acks++;
        end
        checks++;
        if (acks != 1) begin
            failures++;
            $display("FAIL dropped_ack_count: acks=%0d required 1", acks);
        end
        checks++;
        if (busy !== 1'b0 || ack1 !== 1'b0) begin
            failures++;
            $display("FAIL dropped_idle: busy=%b ack1=%b required 0 0", busy, ack1);
        end
    endtask

    task automatic test_reset_mid_access();
        int acks;
        req0 = 1'b1; we0 = 1'b1; addr0 = DEV_HEX; wdata0 = 32'h0000_BEEF;
        step();
        checks++;
        if (wrtEn !== 1'b1) begin
            failures++;
            $display("FAIL midrst_pre: wrtEn=%b required 1", wrtEn);
        end
        #2;
        reset = 1'b1;
        req0 = 1'b0;
        #1;
        checks++;
        if (wrtEn !== 1'b0 || address !== 32'hFFFF_FFFF || busy !== 1'b0 || ack0 !== 1'b0) begin
            failures++;
            $display("FAIL midrst_release: wrtEn=%b addr=%h busy=%b ack0=%b required 0 FFFFFFFF 0 0", wrtEn, address, busy, ack0);
        end
        tb_force = 1'b1;
        #1;
        checks++;
        if (dbus !== PATTERN) begin
            failures++;
            $display("FAIL midrst_dbus_z: dbus=%h required %h", dbus, PATTERN);
        end
        tb_force = 1'b0;
        step();
        reset = 1'b0;
        acks = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (ack0 === 1'b1 || ack1 === 1'b1) acks++;
        end
        checks++;
        if (acks != 0 || hex_reg !== 32'h0000_1234) begin
            failures++;
            $display("FAIL midrst_lost: acks=%0d hex=%h required 0 00001234", acks, hex_reg);
        end
        req0 = 1'b1; we0 = 1'b1; addr0 = DEV_HEX; wdata0 = 32'h0000_4321;
        step();
        req0 = 1'b0;
        checks++;
        if (gnt_id !== 1'b0 || address !== DEV_HEX || wrtEn !== 1'b1) begin
            failures++;
            $display("FAIL midrst_regrant: gnt=%b addr=%h wrtEn=%b required 0 F0000000 1", gnt_id, address, wrtEn);
        end
        step();
        checks++;
        if (ack0 !== 1'b1 || hex_reg !== 32'h0000_4321) begin
            failures++;
            $display("FAIL midrst_reack: ack0=%b hex=%h required 1 00004321", ack0, hex_reg);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_simultaneous();
        test_long_access();
        test_req_dropped();
        test_reset_mid_access();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
